// File: rtl/div32_seq_if.sv
// Operand/result bundle for the sequential 32-bit divider.
// The master side launches a divide and the slave side (the divider) returns the results.
interface div32_seq_if;
  logic        START;
  logic        SIGNED;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic [31:0] QUO;
  logic [31:0] REM;
  logic        BUSY;
  logic        DONE;
  logic        DIV_ZERO;
  logic        OVF;

  modport master (
    output START, SIGNED, DIVIDEND, DIVISOR,
    input  QUO, REM, BUSY, DONE, DIV_ZERO, OVF
  );

  modport slave (
    input  START, SIGNED, DIVIDEND, DIVISOR,
    output QUO, REM, BUSY, DONE, DIV_ZERO, OVF
  );
endinterface

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, signed or unsigned.
// Timing: 32 shift-subtract steps followed by one sign-fix cycle, so DONE
// arrives 34 cycles after START is accepted.
module div32_seq (
  input  logic        CLK,
  input  logic        RST,
  div32_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] a;            // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] p;            // partial remainder; always below the divisor magnitude
  logic [31:0] d_mag;
  logic [31:0] dividend_raw; // kept for the divide-by-zero remainder
  logic        neg_q;
  logic        neg_r;
  logic        dz_l;
  logic        ovf_l;

  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic        busy_r;
  logic        done_r;
  logic        dz_r;
  logic        ovf_r;

  logic [32:0] p_shift;
  logic        ge;
  logic [31:0] diff;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    p_shift = {p, a[31]};
    ge      = (p_shift >= {1'b0, d_mag});
    // When ge holds, the true difference is below d_mag, so 32 bits suffice.
    diff    = p_shift[31:0] - d_mag;
  end

  // Control FSM, datapath registers and registered outputs.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the reset is synchronous because it is checked inside the clocked block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      a            <= '0;
      p            <= '0;
      d_mag        <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz_l         <= 1'b0;
      ovf_l        <= 1'b0;
      quo_r        <= '0;
      rem_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dz_r         <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            a            <= mag(bus.DIVIDEND, bus.SIGNED & bus.DIVIDEND[31]);
            d_mag        <= mag(bus.DIVISOR,  bus.SIGNED & bus.DIVISOR[31]);
            p            <= '0;
            dividend_raw <= bus.DIVIDEND;
            neg_q        <= bus.SIGNED & (bus.DIVIDEND[31] ^ bus.DIVISOR[31]);
            neg_r        <= bus.SIGNED & bus.DIVIDEND[31];
            dz_l         <= (bus.DIVISOR == 32'd0);
            ovf_l        <= bus.SIGNED && (bus.DIVIDEND == 32'h8000_0000)
                                       && (bus.DIVISOR  == 32'hFFFF_FFFF);
            cnt          <= 5'd31;
            busy_r       <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          a   <= {a[30:0], ge};
          p   <= ge ? diff : p_shift[31:0];
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          if (dz_l) begin
            quo_r <= 32'hFFFF_FFFF;
            rem_r <= dividend_raw;
          end else if (ovf_l) begin
            quo_r <= 32'h8000_0000;
            rem_r <= 32'd0;
          end else begin
            quo_r <= mag(a, neg_q);
            rem_r <= mag(p, neg_r);
          end
          dz_r   <= dz_l;
          ovf_r  <= ovf_l & ~dz_l;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.QUO      = quo_r;
  assign bus.REM      = rem_r;
  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;
  assign bus.DIV_ZERO = dz_r;
  assign bus.OVF      = ovf_r;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, handshake corner
// sequences (re-START while busy, START in DONE cycle, mid-operation reset)
// and random operands checked against the division invariant.
module tb_div32_seq;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  div32_seq_if bus ();

  div32_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle (or in its DONE cycle).
  // Returns at the negedge of cycle k+1 with operands scrambled.
  task automatic launch(input logic sgn, input logic [31:0] dd, input logic [31:0] dv);
    bus.START    = 1'b1;
    bus.SIGNED   = sgn;
    bus.DIVIDEND = dd;
    bus.DIVISOR  = dv;
    @(posedge CLK);
    @(negedge CLK);
    bus.START    = 1'b0;
    bus.SIGNED   = ~sgn;
    bus.DIVIDEND = $urandom;
    bus.DIVISOR  = $urandom;
  endtask

  // Follows one operation cycle by cycle from k+1. lat = cycle of DONE,
  // -1 on timeout, -2 when a reset was injected at cycle rst_at.
  task automatic wait_done(input string tag, input int repulse_at, input int rst_at,
                           input logic [31:0] hold_q, output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge CLK);
      if (c == rst_at) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        lat = -2;
        break;
      end
      if (bus.DONE === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.BUSY !== 1'b1) busy_ok = 1'b0;
      if (c == 20) check({tag, " quo_hold_while_busy"}, bus.QUO, hold_q);
      if (c == repulse_at) begin
        bus.START    = 1'b1;
        bus.SIGNED   = 1'b0;
        bus.DIVIDEND = 32'd999;
        bus.DIVISOR  = 32'd3;
      end
      if (c == repulse_at + 1) bus.START = 1'b0;
    end
    if (lat != -2) begin
      check({tag, " latency"}, lat, 34);
      check({tag, " busy_k1_to_k33"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " busy_low_in_done"}, {31'd0, bus.BUSY}, 32'd0);
    end
  endtask

  logic [31:0] last_q;

  task automatic do_op(input string tag, input vec_t v, input int repulse_at);
    int lat;
    launch(v.sgn, v.dd, v.dv);
    wait_done(tag, repulse_at, 0, last_q, lat);
    check({tag, " quo"}, bus.QUO, v.q);
    check({tag, " rem"}, bus.REM, v.r);
    check({tag, " div_zero"}, {31'd0, bus.DIV_ZERO}, {31'd0, v.dz});
    check({tag, " ovf"}, {31'd0, bus.OVF}, {31'd0, v.ovf});
    last_q = v.q;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic saw_done;
    vec_t v;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 1'b0};

    RST          = 1'b1;
    bus.START    = 1'b0;
    bus.SIGNED   = 1'b0;
    bus.DIVIDEND = '0;
    bus.DIVISOR  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset quo",  bus.QUO, 32'd0);
    check("reset rem",  bus.REM, 32'd0);
    check("reset busy", {31'd0, bus.BUSY}, 32'd0);
    check("reset done", {31'd0, bus.DONE}, 32'd0);
    check("reset dz",   {31'd0, bus.DIV_ZERO}, 32'd0);
    check("reset ovf",  {31'd0, bus.OVF}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    last_q = 32'd0;

    // Each op after the first is launched in the previous DONE cycle, so
    // the latency check also covers back-to-back acceptance.
    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i], 0);

    // START re-pulsed at k+10 with 999/3 must be ignored.
    v = '{1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0};
    do_op("repulse", v, 10);

    // START in the DONE cycle, signed this time.
    v = '{1'b1, 32'hFFFF_FC18, 32'd10, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b0};
    do_op("b2b", v, 0);

    // Reset at k+15 aborts the divide.
    launch(1'b0, 32'd50, 32'd5);
    wait_done("rst", 0, 15, last_q, lat);
    check("midrst injected", lat, -2);
    check("midrst quo",  bus.QUO, 32'd0);
    check("midrst rem",  bus.REM, 32'd0);
    check("midrst busy", {31'd0, bus.BUSY}, 32'd0);
    check("midrst done", {31'd0, bus.DONE}, 32'd0);
    check("midrst dz",   {31'd0, bus.DIV_ZERO}, 32'd0);
    check("midrst ovf",  {31'd0, bus.OVF}, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) saw_done = 1'b1;
    end
    check("midrst no_done_after", {31'd0, saw_done}, 32'd0);
    last_q = 32'd0;
    v = '{1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0};
    do_op("after_rst", v, 0);

    // Random operands, checked against the division invariant.
    for (int i = 0; i < 16; i++) begin
      logic        sgn;
      logic [31:0] dd, dv;
      logic        ok;
      sgn = i[0];
      dd  = $urandom;
      dv  = $urandom >> $urandom_range(0, 31);
      if (dv == 32'd0) dv = 32'd1;
      if (sgn && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) dv = 32'd3;
      launch(sgn, dd, dv);
      wait_done($sformatf("rand%0d", i), 0, 0, last_q, lat);
      if (!sgn) begin
        longint unsigned uq, ur, ud, udd;
        uq  = bus.QUO;
        ur  = bus.REM;
        ud  = dv;
        udd = dd;
        ok  = (uq * ud + ur == udd) && (ur < ud);
      end else begin
        longint sq, sr, sd, sdd, ar, ad;
        sq  = $signed(bus.QUO);
        sr  = $signed(bus.REM);
        sd  = $signed(dv);
        sdd = $signed(dd);
        ar  = (sr < 0) ? -sr : sr;
        ad  = (sd < 0) ? -sd : sd;
        ok  = (sq * sd + sr == sdd) && (ar < ad) && (sr == 0 || ((sr < 0) == (sdd < 0)));
      end
      check($sformatf("rand%0d invariant sgn=%0d %08h/%08h", i, sgn, dd, dv), {31'd0, ok}, 32'd1);
      check($sformatf("rand%0d flags", i), {30'd0, bus.DIV_ZERO, bus.OVF}, 32'd0);
      last_q = bus.QUO;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
